// File: rtl/source_msg_buffer_pkg.sv
// Shared types and limits for the per-source message buffers.
// Descriptors are {parity, 8-bit length}; lengths 1..255.
package source_msg_buffer_pkg;

    localparam int NUM_SOURCES    = 4;
    localparam int MAX_MSG_LEN    = 255;
    localparam int MSG_IDLE_LIMIT = 64;
    localparam int DESC_W         = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DROP    = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic       parity;
        logic [7:0] len;
    } msg_desc_t;

endpackage

// File: rtl/source_msg_buffer_if.sv
// Deserializer-side word input plus the USB writer-side message handshake.
// master drives words and read strobes; slave is the buffer.
interface source_msg_buffer_if #(parameter int ADDR_W = 9);

    logic [15:0]     DIN;
    logic            DIN_VALID;
    logic            DIN_LAST;
    logic            DIN_PARITY;
    logic [15:0]     Q;
    logic            GOT_FULL_MSG;
    logic [7:0]      MSG_LEN;
    logic            PARITY;
    logic            RD_REQ;
    logic            MSG_SENT;
    logic            OVERFLOW;
    logic [7:0]      DROP_COUNT;
    logic [ADDR_W:0] LEVEL;

    modport master (
        output DIN, DIN_VALID, DIN_LAST, DIN_PARITY, RD_REQ, MSG_SENT,
        input  Q, GOT_FULL_MSG, MSG_LEN, PARITY, OVERFLOW, DROP_COUNT, LEVEL
    );

    modport slave (
        input  DIN, DIN_VALID, DIN_LAST, DIN_PARITY, RD_REQ, MSG_SENT,
        output Q, GOT_FULL_MSG, MSG_LEN, PARITY, OVERFLOW, DROP_COUNT, LEVEL
    );

endinterface

// File: rtl/source_msg_buffer_msg_len_queue.sv
// Small synchronous descriptor FIFO with combinational (show-ahead) head.
// Push when full and pop when empty are ignored; head reads 0 while empty.
module msg_len_queue #(
    parameter int AW = 2,
    parameter int DW = 9
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic          empty,
    output logic          full
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] P_ONE = 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_p;
    logic [AW:0]   rd_p;

    assign empty    = (wr_p == rd_p);
    assign full     = (wr_p[AW] != rd_p[AW]) && (wr_p[AW-1:0] == rd_p[AW-1:0]);
    assign head_dat = empty ? '0 : mem[rd_p[AW-1:0]];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_p <= '0;
            rd_p <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_p[AW-1:0]] <= push_dat;
                wr_p              <= wr_p + P_ONE;
            end
            if (pop && !empty) begin
                rd_p <= rd_p + P_ONE;
            end
        end
    end

endmodule

// File: rtl/source_msg_buffer.sv
// Frames deserializer words into 1..MAX_LEN word messages in a circular buffer; Q is show-ahead, commit visible next cycle.
// No backpressure to the source: a message that meets a full buffer or descriptor queue is dropped whole and counted.
module source_msg_buffer
    import source_msg_buffer_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int LENQ_W     = 2,
    parameter int IDLE_LIMIT = MSG_IDLE_LIMIT,
    parameter int MAX_LEN    = MAX_MSG_LEN
) (
    input  logic                 CLK,
    input  logic                 RST,
    source_msg_buffer_if.slave   bus
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_P   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE   = 1;
    localparam logic [7:0]      MAX_LEN8  = 8'(MAX_LEN);
    localparam logic [7:0]      IDLE_LAST = 8'(IDLE_LIMIT - 1);

    logic [15:0]     mem [DEPTH];
    logic [ADDR_W:0] wr_ptr, wr_ptr_nx, rd_ptr, commit_ptr, msg_start;
    logic [7:0]      word_cnt, idle_cnt, commit_len, drop_cnt;
    logic            msg_parity, msg_sent_q, overflow_q;
    logic            wr_en, start, close, commit, drop, rd_en, buf_full;
    wr_state_t       state, state_nx;

    msg_desc_t       push_desc, head_desc;
    logic            lenq_empty, lenq_full, lenq_pop;

    // wr_ptr runs ahead of commit_ptr while a message is open; rd_ptr never passes commit_ptr.
    assign buf_full = ((wr_ptr - rd_ptr) == DEPTH_P);
    assign rd_en    = bus.RD_REQ && !lenq_empty && (rd_ptr != commit_ptr);
    assign lenq_pop = bus.MSG_SENT && !msg_sent_q;

    always_comb begin
        state_nx   = state;
        wr_en      = 1'b0;
        start      = 1'b0;
        close      = 1'b0;
        commit     = 1'b0;
        drop       = 1'b0;
        commit_len = word_cnt;
        case (state)
            ST_IDLE: begin
                if (bus.DIN_VALID) begin
                    if (buf_full) begin
                        drop     = 1'b1;
                        state_nx = bus.DIN_LAST ? ST_IDLE : ST_DROP;
                    end else begin
                        wr_en      = 1'b1;
                        start      = 1'b1;
                        commit_len = 8'd1;
                        if (bus.DIN_LAST || (MAX_LEN8 == 8'd1)) begin
                            close = 1'b1;
                        end else begin
                            state_nx = ST_COLLECT;
                        end
                    end
                end
            end
            ST_COLLECT: begin
                if (bus.DIN_VALID) begin
                    if (buf_full) begin
                        drop     = 1'b1;
                        state_nx = bus.DIN_LAST ? ST_IDLE : ST_DROP;
                    end else begin
                        wr_en      = 1'b1;
                        commit_len = word_cnt + 8'd1;
                        close      = bus.DIN_LAST || (commit_len == MAX_LEN8);
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    close = 1'b1;
                end
            end
            ST_DROP: begin
                if (bus.DIN_VALID && bus.DIN_LAST) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (close) begin
            state_nx = ST_IDLE;
            if (lenq_full) begin
                drop = 1'b1;
            end else begin
                commit = 1'b1;
            end
        end

        wr_ptr_nx = wr_en ? (wr_ptr + PTR_ONE) : wr_ptr;
        // In IDLE the message start is still wr_ptr itself.
        if (drop) begin
            wr_ptr_nx = (state == ST_COLLECT) ? msg_start : wr_ptr;
        end
    end

    assign push_desc.parity = start ? bus.DIN_PARITY : msg_parity;
    assign push_desc.len    = commit_len;

    msg_len_queue #(
        .AW (LENQ_W),
        .DW (DESC_W)
    ) u_lenq (
        .CLK      (CLK),
        .RST      (RST),
        .push     (commit),
        .push_dat (push_desc),
        .pop      (lenq_pop),
        .head_dat (head_desc),
        .empty    (lenq_empty),
        .full     (lenq_full)
    );

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.DIN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            commit_ptr <= '0;
            msg_start  <= '0;
            word_cnt   <= '0;
            idle_cnt   <= '0;
            msg_parity <= 1'b0;
            msg_sent_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_nx;
            wr_ptr     <= wr_ptr_nx;
            msg_sent_q <= bus.MSG_SENT;
            overflow_q <= drop;
            if (start) begin
                msg_start  <= wr_ptr;
                msg_parity <= bus.DIN_PARITY;
                word_cnt   <= 8'd1;
            end else if (wr_en) begin
                word_cnt <= word_cnt + 8'd1;
            end
            if ((state == ST_COLLECT) && !bus.DIN_VALID && !close) begin
                idle_cnt <= idle_cnt + 8'd1;
            end else begin
                idle_cnt <= '0;
            end
            if (commit) begin
                commit_ptr <= wr_ptr_nx;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign bus.Q            = (rd_ptr != commit_ptr) ? mem[rd_ptr[ADDR_W-1:0]] : 16'h0000;
    assign bus.GOT_FULL_MSG = !lenq_empty;
    assign bus.MSG_LEN      = head_desc.len;
    assign bus.PARITY       = head_desc.parity;
    assign bus.OVERFLOW     = overflow_q;
    assign bus.DROP_COUNT   = drop_cnt;
    assign bus.LEVEL        = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_source_msg_buffer.sv
// Directed bench for source_msg_buffer: framing, length cap, idle close, drops, wrap and reset.
module tb_source_msg_buffer;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    source_msg_buffer_if #(.ADDR_W(9)) bus ();

    source_msg_buffer #(
        .ADDR_W     (9),
        .LENQ_W     (2),
        .IDLE_LIMIT (64),
        .MAX_LEN    (255)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_msg(input logic [15:0] base, input logic [15:0] step, input int n,
                            input logic last, input logic par);
        for (int i = 0; i < n; i++) begin
            bus.DIN        = 16'(base + 16'(i) * step);
            bus.DIN_VALID  = 1'b1;
            bus.DIN_LAST   = last && (i == n - 1);
            bus.DIN_PARITY = par;
            tick();
        end
        bus.DIN_VALID = 1'b0;
        bus.DIN_LAST  = 1'b0;
    endtask

    task automatic read_msg(input string tag, input logic [15:0] base, input logic [15:0] step, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(bus.Q), 32'(16'(base + 16'(i) * step)));
            bus.RD_REQ = 1'b1;
            tick();
            bus.RD_REQ = 1'b0;
            tick();
        end
    endtask

    task automatic msg_sent();
        bus.MSG_SENT = 1'b1;
        tick();
        bus.MSG_SENT = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q"},     32'(bus.Q),            32'h0);
        check({tag, "_got"},   32'(bus.GOT_FULL_MSG), 32'h0);
        check({tag, "_len"},   32'(bus.MSG_LEN),      32'h0);
        check({tag, "_par"},   32'(bus.PARITY),       32'h0);
        check({tag, "_ovf"},   32'(bus.OVERFLOW),     32'h0);
        check({tag, "_drops"}, 32'(bus.DROP_COUNT),   32'h0);
        check({tag, "_level"}, 32'(bus.LEVEL),        32'h0);
    endtask

    initial begin
        bus.DIN        = '0;
        bus.DIN_VALID  = 1'b0;
        bus.DIN_LAST   = 1'b0;
        bus.DIN_PARITY = 1'b0;
        bus.RD_REQ     = 1'b0;
        bus.MSG_SENT   = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        RST = 1'b1;
        tick();

        // RD_REQ with nothing committed must not move the read pointer.
        bus.RD_REQ = 1'b1;
        tick();
        bus.RD_REQ = 1'b0;
        tick();

        // Single 4-word message; parity taken from the first word only.
        send_msg(16'h1111, 16'h1111, 3, 1'b0, 1'b1);
        check("single_open_got", 32'(bus.GOT_FULL_MSG), 32'h0);
        check("single_open_level", 32'(bus.LEVEL), 32'd3);
        check("single_open_q", 32'(bus.Q), 32'h0);
        send_msg(16'h4444, 16'h1111, 1, 1'b1, 1'b0);
        check("single_got", 32'(bus.GOT_FULL_MSG), 32'h1);
        check("single_len", 32'(bus.MSG_LEN), 32'd4);
        check("single_par", 32'(bus.PARITY), 32'h1);
        check("single_level", 32'(bus.LEVEL), 32'd4);
        read_msg("single_q", 16'h1111, 16'h1111, 4);
        check("single_level_drained", 32'(bus.LEVEL), 32'd0);
        msg_sent();
        check("single_sent_got", 32'(bus.GOT_FULL_MSG), 32'h0);

        // Length cap: 300 words without DIN_LAST split into 255 + 45.
        send_msg(16'h5000, 16'h0001, 300, 1'b0, 1'b0);
        check("cap_got", 32'(bus.GOT_FULL_MSG), 32'h1);
        check("cap_len0", 32'(bus.MSG_LEN), 32'd255);
        check("cap_level", 32'(bus.LEVEL), 32'd300);
        repeat (64) tick();
        read_msg("cap_q0", 16'h5000, 16'h0001, 255);
        msg_sent();
        check("cap_len1", 32'(bus.MSG_LEN), 32'd45);
        check("cap_got1", 32'(bus.GOT_FULL_MSG), 32'h1);
        read_msg("cap_q1", 16'h50FF, 16'h0001, 45);
        msg_sent();
        check("cap_done_got", 32'(bus.GOT_FULL_MSG), 32'h0);

        // Idle timeout: commit lands on exactly the 64th idle cycle.
        send_msg(16'hA000, 16'h0001, 3, 1'b0, 1'b0);
        repeat (63) tick();
        check("idle_63_got", 32'(bus.GOT_FULL_MSG), 32'h0);
        tick();
        check("idle_64_got", 32'(bus.GOT_FULL_MSG), 32'h1);
        check("idle_len", 32'(bus.MSG_LEN), 32'd3);
        send_msg(16'hB001, 16'h0001, 2, 1'b1, 1'b1);
        check("idle_head_len", 32'(bus.MSG_LEN), 32'd3);
        read_msg("idle_q0", 16'hA000, 16'h0001, 3);
        msg_sent();
        check("idle_len2", 32'(bus.MSG_LEN), 32'd2);
        check("idle_par2", 32'(bus.PARITY), 32'h1);
        read_msg("idle_q1", 16'hB001, 16'h0001, 2);
        msg_sent();
        check("idle_done_got", 32'(bus.GOT_FULL_MSG), 32'h0);

        // Descriptor queue full: fifth one-word message is dropped.
        for (int k = 0; k < 4; k++) begin
            send_msg(16'(16'hC000 + k), 16'h0001, 1, 1'b1, 1'b0);
        end
        check("lenq_pre_ovf", 32'(bus.OVERFLOW), 32'h0);
        send_msg(16'hC004, 16'h0001, 1, 1'b1, 1'b0);
        check("lenq_ovf", 32'(bus.OVERFLOW), 32'h1);
        check("lenq_drops", 32'(bus.DROP_COUNT), 32'd1);
        check("lenq_level", 32'(bus.LEVEL), 32'd4);
        tick();
        check("lenq_ovf_clear", 32'(bus.OVERFLOW), 32'h0);
        for (int k = 0; k < 4; k++) begin
            check("lenq_len", 32'(bus.MSG_LEN), 32'd1);
            read_msg("lenq_q", 16'(16'hC000 + k), 16'h0001, 1);
            msg_sent();
        end
        check("lenq_done_got", 32'(bus.GOT_FULL_MSG), 32'h0);

        // Pad so the fill below starts at buffer index 507.
        send_msg(16'hD000, 16'h0001, 194, 1'b1, 1'b0);
        check("pad_len", 32'(bus.MSG_LEN), 32'd194);
        read_msg("pad_q", 16'hD000, 16'h0001, 194);
        msg_sent();
        check("pad_level", 32'(bus.LEVEL), 32'd0);

        // Buffer full, drop with rewind, then a message stored across the wrap.
        send_msg(16'h1000, 16'h0001, 255, 1'b1, 1'b0);
        send_msg(16'h2000, 16'h0001, 255, 1'b1, 1'b1);
        send_msg(16'h3000, 16'h0001, 2, 1'b1, 1'b0);
        check("full_level", 32'(bus.LEVEL), 32'd512);
        send_msg(16'h4000, 16'h0001, 1, 1'b0, 1'b0);
        check("full_ovf", 32'(bus.OVERFLOW), 32'h1);
        send_msg(16'h4001, 16'h0001, 9, 1'b1, 1'b0);
        check("full_ovf_once", 32'(bus.OVERFLOW), 32'h0);
        check("full_drops", 32'(bus.DROP_COUNT), 32'd2);
        check("full_level_kept", 32'(bus.LEVEL), 32'd512);
        check("full_head_len", 32'(bus.MSG_LEN), 32'd255);
        read_msg("full_qa", 16'h1000, 16'h0001, 255);
        msg_sent();
        check("full_level_a", 32'(bus.LEVEL), 32'd257);
        send_msg(16'hE000, 16'h0001, 10, 1'b1, 1'b0);
        check("wrap_level", 32'(bus.LEVEL), 32'd267);
        check("wrap_par_b", 32'(bus.PARITY), 32'h1);
        read_msg("full_qb", 16'h2000, 16'h0001, 255);
        msg_sent();
        check("full_len_c", 32'(bus.MSG_LEN), 32'd2);
        read_msg("full_qc", 16'h3000, 16'h0001, 2);
        msg_sent();
        check("wrap_len", 32'(bus.MSG_LEN), 32'd10);
        read_msg("wrap_q", 16'hE000, 16'h0001, 10);
        msg_sent();
        check("wrap_done_got", 32'(bus.GOT_FULL_MSG), 32'h0);
        check("wrap_done_level", 32'(bus.LEVEL), 32'd0);

        // Reset in the middle of an open message.
        send_msg(16'hF000, 16'h0001, 4, 1'b0, 1'b1);
        bus.DIN       = 16'hF004;
        bus.DIN_VALID = 1'b1;
        #1;
        RST = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        bus.DIN_VALID = 1'b0;
        RST = 1'b1;
        tick();
        send_msg(16'h7000, 16'h0001, 3, 1'b1, 1'b1);
        check("post_rst_len", 32'(bus.MSG_LEN), 32'd3);
        check("post_rst_par", 32'(bus.PARITY), 32'h1);
        check("post_rst_level", 32'(bus.LEVEL), 32'd3);
        read_msg("post_rst_q", 16'h7000, 16'h0001, 3);
        msg_sent();
        check("post_rst_got", 32'(bus.GOT_FULL_MSG), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
